fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter data_width, default 8, sample, coefficient and RAM data width.
REQ-002 Parameter addr_width, default 3, tap-address width; tap count TAPS = 2**addr_width (8).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears while reset = 0.
REQ-005 x_in  input  data_width  input sample.
REQ-006 in_valid  input  1  x_in valid.
REQ-007 in_ready  output  1  controller can accept a sample; transfer when in_valid & in_ready at a clock edge.
REQ-008 clr  input  1  request to zero the delay line; sampled only in IDLE.
REQ-009 ram_we  output  1  delay-line RAM write enable.
REQ-010 ram_waddr  output  addr_width  RAM write address.
REQ-011 ram_wdata  output  data_width  RAM write data.
REQ-012 ram_raddr  output  addr_width  RAM read address; RAM read is combinational.
REQ-013 rom_addr  output  addr_width  coefficient ROM address; ROM read is combinational.
REQ-014 mac_init  output  1  to MAC: 1 loads product, 0 accumulates.
REQ-015 y  input  data_width*2+3  registered MAC accumulator.
REQ-016 y_out  output  data_width*2+3  filter output sample.
REQ-017 out_valid  output  1  y_out valid.
REQ-018 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready at a clock edge.

Function
REQ-019 FSM states CLEAR, IDLE, MAC, DONE, OUT; exactly one active.
REQ-020 Registers: write pointer wptr (addr_width), tap counter k (addr_width), y_out, out_valid.
REQ-021 CLEAR: ram_we=1, ram_waddr=k, ram_wdata=0, k increments each cycle; k=TAPS-1 -> IDLE, k<=0, wptr<=0; lasts exactly TAPS cycles.
REQ-022 IDLE: in_ready=1; clr=1 -> CLEAR, in_ready=0, and no write (clr priority over in_valid).
REQ-023 IDLE with in_valid=1, clr=0: ram_we=1, ram_waddr=wptr, ram_wdata=x_in (combinational); next state MAC, k<=0.
REQ-024 MAC: rom_addr=k, ram_raddr=(wptr-k) mod TAPS, mac_init=1 only when k=0; k increments; k=TAPS-1 -> DONE; lasts exactly TAPS cycles.
REQ-025 DONE: y_out<=y, out_valid<=1, wptr<=wptr+1 mod TAPS (wraps TAPS-1 -> 0); next OUT; one cycle.
REQ-026 OUT: y_out, out_valid held stable until out_ready=1; on transfer out_valid<=0, next IDLE.
REQ-027 in_ready=0 and ram_we=0 in MAC, DONE, OUT; mac_init=0 outside MAC; rom_addr and ram_raddr=0 outside MAC.
REQ-028 Latency: sample accepted at edge E -> out_valid=1 after edge E+TAPS+1; minimum sample period TAPS+3 cycles.
REQ-029 y_out = sum over k=0..TAPS-1 of h[k]*x[n-k], unsigned, no truncation; width 2*data_width+3 holds the 8x255*255 = 520200 maximum.
REQ-030 in_valid and x_in are ignored while in_ready=0; no sample is lost or duplicated.

Reset
REQ-031 reset=0 forces state CLEAR, k=0, wptr=0, y_out=0, out_valid=0, in_ready=0, immediately and asynchronously, from any state.
REQ-032 On reset release, TAPS CLEAR cycles run before in_ready first rises; reset during MAC discards the partial result and produces no output.

Verification
REQ-033 Impulse: ROM h=1..8, reset, x=1 then seven x=0 -> y_out sequence 1,2,3,4,5,6,7,8; ninth x=0 -> 0.
REQ-034 Max value: h=255 all taps, eight x=255 -> eighth y_out=520200, no overflow.
REQ-035 Backpressure: out_ready=0 for 5 cycles in OUT -> y_out, out_valid stable, in_ready=0; out_ready=1 -> one transfer, IDLE next cycle.
REQ-036 Wrap: feed 9 samples x=1..9, h=1 all taps -> ninth y_out=2+...+9=44; wptr back to 1.
REQ-037 Clear: after samples 5,5, clr=1 with in_valid=1 in IDLE -> 8 zero writes, x dropped; next x=3, h=1 -> y_out=3.
REQ-038 Reset mid-MAC at k=4 -> out_valid stays 0, after release CLEAR runs 8 cycles, then in_ready=1.

Source files
------------

// File: rtl/fir_ctrl.sv
// Sequencer for a time-multiplexed 8-tap FIR filter: owns the delay-line RAM write port,
// walks the taps through an external MAC, and hands each finished sum downstream.
module fir_ctrl #(
  parameter int data_width = 8,
  parameter int addr_width = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [data_width-1:0]     x_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      clr,
  output logic                      ram_we,
  output logic [addr_width-1:0]     ram_waddr,
  output logic [data_width-1:0]     ram_wdata,
  output logic [addr_width-1:0]     ram_raddr,
  output logic [addr_width-1:0]     rom_addr,
  output logic                      mac_init,
  input  logic [2*data_width+2:0]   y,
  output logic [2*data_width+2:0]   y_out,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [addr_width-1:0] K_LAST = '1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_MAC,
    S_DONE,
    S_OUT
  } state_t;

  state_t                state;
  logic [addr_width-1:0] wptr;
  logic [addr_width-1:0] k;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_CLEAR;
      k         <= '0;
      wptr      <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          k <= k + 1'b1;
          if (k == K_LAST) begin
            state <= S_IDLE;
            k     <= '0;
            wptr  <= '0;
          end
        end
        // clr outranks a pending sample so a clear request can never be starved
        S_IDLE: begin
          if (clr) begin
            state <= S_CLEAR;
            k     <= '0;
          end else if (in_valid) begin
            state <= S_MAC;
            k     <= '0;
          end
        end
        S_MAC: begin
          k <= k + 1'b1;
          if (k == K_LAST) begin
            state <= S_DONE;
            k     <= '0;
          end
        end
        // the MAC register holds the complete sum one edge after the last tap
        S_DONE: begin
          y_out     <= y;
          out_valid <= 1'b1;
          wptr      <= wptr + 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    rom_addr  = '0;
    mac_init  = 1'b0;
    case (state)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = k;
      end
      S_IDLE: begin
        in_ready  = !clr;
        ram_we    = in_valid && !clr;
        ram_waddr = wptr;
        ram_wdata = x_in;
      end
      // newest sample sits at wptr, older ones at descending addresses (mod TAPS)
      S_MAC: begin
        rom_addr  = k;
        ram_raddr = wptr - k;
        mac_init  = (k == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with behavioural delay-line RAM, coefficient ROM and MAC.
module tb_fir_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  x_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clr = 1'b0;
  logic        ram_we;
  logic [2:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic [2:0]  ram_raddr;
  logic [2:0]  rom_addr;
  logic        mac_init;
  logic [18:0] y = '0;
  logic [18:0] y_out;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [7:0]  ram [8] = '{default: 8'hAA};
  logic [7:0]  rom [8];
  logic [18:0] prod;

  int          tests = 0;
  int          failed = 0;
  logic [2:0]  exp_wptr = '0;

  fir_ctrl #(.data_width(8), .addr_width(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .rom_addr  (rom_addr),
    .mac_init  (mac_init),
    .y         (y),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  assign prod = {11'd0, rom[rom_addr]} * {11'd0, ram[ram_raddr]};

  always @(posedge clock) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    y <= mac_init ? prod : y + prod;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rom_ramp();
    for (int i = 0; i < 8; i++) rom[i] = 8'(i + 1);
  endtask

  task automatic set_rom_const(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rom[i] = v;
  endtask

  task automatic do_reset(input string tag);
    int n;
    reset = 1'b0;
    #1;
    chk({tag, "_rst_in_ready"}, in_ready, 0);
    chk({tag, "_rst_out_valid"}, out_valid, 0);
    chk({tag, "_rst_y_out"}, y_out, 0);
    chk({tag, "_rst_clear_we"}, ram_we, 1);
    chk({tag, "_rst_clear_addr"}, ram_waddr, 0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_clear_len"}, n, 8);
    exp_wptr = '0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic send(input logic [7:0] xv, input logic [18:0] exp, input int hold, input string tag);
    int n;
    wait_ready(tag);
    x_in = xv;
    in_valid = 1'b1;
    #1;
    chk({tag, "_we"}, ram_we, 1);
    chk({tag, "_waddr"}, ram_waddr, exp_wptr);
    chk({tag, "_wdata"}, ram_wdata, xv);
    @(negedge clock);
    in_valid = 1'b0;
    x_in = 8'h5A;
    n = 0;
    while (!out_valid && n < 40) begin
      chk({tag, "_busy_ready"}, in_ready, 0);
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_y"}, y_out, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_y"}, y_out, exp);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_we"}, ram_we, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_xfer_valid"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    exp_wptr = exp_wptr + 1'b1;
  endtask

  initial begin
    int  n;
    logic saw_valid;

    #2;
    do_reset("init");

    // Impulse through a 1..8 ramp; RAM starts as 0xAA garbage so CLEAR must have zeroed it
    set_rom_ramp();
    send(8'd1, 19'd1, 0, "imp0");
    for (int i = 1; i < 8; i++) send(8'd0, 19'(i + 1), 0, $sformatf("imp%0d", i));
    send(8'd0, 19'd0, 0, "imp8");

    // Full-scale sums with backpressure on the last result
    do_reset("max");
    set_rom_const(8'd255);
    for (int i = 0; i < 8; i++)
      send(8'd255, 19'(65025 * (i + 1)), (i == 7) ? 5 : 0, $sformatf("max%0d", i));

    // Write-pointer wrap with unity taps
    do_reset("wrap");
    set_rom_const(8'd1);
    for (int i = 1; i <= 8; i++) send(8'(i), 19'(i * (i + 1) / 2), 0, $sformatf("wrap%0d", i));
    send(8'd9, 19'd44, 0, "wrap9");
    send(8'd10, 19'd52, 0, "wrap10");

    // Clear request beats a simultaneous sample
    do_reset("clr");
    send(8'd5, 19'd5, 0, "clr_a");
    send(8'd5, 19'd10, 0, "clr_b");
    clr = 1'b1;
    in_valid = 1'b1;
    x_in = 8'd77;
    #1;
    chk("clr_in_ready", in_ready, 0);
    chk("clr_no_write", ram_we, 0);
    @(negedge clock);
    clr = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_we%0d", i), ram_we, 1);
      chk($sformatf("clr_addr%0d", i), ram_waddr, i);
      chk($sformatf("clr_data%0d", i), ram_wdata, 0);
      chk($sformatf("clr_busy%0d", i), in_ready, 0);
      @(negedge clock);
    end
    chk("clr_done_ready", in_ready, 1);
    exp_wptr = '0;
    send(8'd3, 19'd3, 0, "clr_x3");

    // Reset while the MAC walk is at tap 4
    do_reset("mid");
    set_rom_ramp();
    send(8'd4, 19'd4, 0, "mid_pre");
    wait_ready("mid");
    x_in = 8'd9;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("mid_k0_init", mac_init, 1);
    chk("mid_k0_rom", rom_addr, 0);
    chk("mid_k0_raddr", ram_raddr, 1);
    @(negedge clock);
    chk("mid_k1_init", mac_init, 0);
    chk("mid_k1_rom", rom_addr, 1);
    chk("mid_k1_raddr", ram_raddr, 0);
    repeat (3) @(negedge clock);
    chk("mid_k4_rom", rom_addr, 4);
    chk("mid_k4_raddr", ram_raddr, 5);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_init", mac_init, 0);
    chk("mid_rst_rom", rom_addr, 0);
    chk("mid_rst_we", ram_we, 1);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    saw_valid = 1'b0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      if (out_valid) saw_valid = 1'b1;
      n++;
    end
    chk("mid_clear_len", n, 8);
    chk("mid_no_output", saw_valid, 0);
    exp_wptr = '0;
    send(8'd2, 19'd2, 0, "mid_post");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
